// File: rtl/maxpool_sched.sv
// maxpool_sched: sequences a 2x2/stride-2 max-pool over one raster-order frame,
// buffering each even row and driving an external 1-cycle-latency maxpool unit.
module maxpool_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic [PIX_W-1:0]          in_pixel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [PIX_W-1:0]          mp_pixel1,
  output logic [PIX_W-1:0]          mp_pixel2,
  output logic [PIX_W-1:0]          mp_pixel3,
  output logic [PIX_W-1:0]          mp_pixel4,
  input  logic [PIX_W-1:0]          mp_maximum,
  output logic [PIX_W-1:0]          out_pixel,
  output logic [$clog2(IMG_H/2):0]  out_row,
  output logic [$clog2(IMG_W/2):0]  out_col,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int ORW = $clog2(IMG_H/2) + 1;
  localparam int OCW = $clog2(IMG_W/2) + 1;

  typedef enum logic [2:0] {IDLE, FILL, PAIR, WAIT, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [PIX_W-1:0]  hold;
  logic              wait_ph;
  logic [PIX_W-1:0]  line_buf [IMG_W];
  logic              in_xfer;
  logic              out_xfer;
  logic              col_last;
  logic              row_last;

  // An issue at an odd column must not clobber an output that is still pending.
  assign in_ready = (state == FILL) ||
                    ((state == PAIR) && !(col[0] && out_valid && !out_ready));
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // Even-row line buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == FILL && in_xfer) begin
      line_buf[col] <= in_pixel;
    end
  end

  // Main sequencer: counters, window issue, result capture and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      wait_ph   <= 1'b0;
      mp_pixel1 <= '0;
      mp_pixel2 <= '0;
      mp_pixel3 <= '0;
      mp_pixel4 <= '0;
      out_pixel <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_xfer) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (in_xfer) begin
            if (col_last) begin
              col   <= '0;
              row   <= row + RW'(1);
              state <= PAIR;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        PAIR: begin
          if (in_xfer) begin
            if (!col[0]) begin
              hold <= in_pixel;
              col  <= col + CW'(1);
            end else begin
              mp_pixel1 <= line_buf[col - CW'(1)];
              mp_pixel2 <= line_buf[col];
              mp_pixel3 <= hold;
              mp_pixel4 <= in_pixel;
              wait_ph   <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // First cycle lets the unit register the window; second captures it.
          if (!wait_ph) begin
            wait_ph <= 1'b1;
          end else begin
            out_pixel <= mp_maximum;
            out_row   <= ORW'(row >> 1);
            out_col   <= OCW'(col >> 1);
            out_valid <= 1'b1;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                state <= DRAIN;
              end else begin
                row   <= row + RW'(1);
                state <= FILL;
              end
            end else begin
              col   <= col + CW'(1);
              state <= PAIR;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_sched.sv
// tb_maxpool_sched: directed self-checking bench for maxpool_sched, using a 4x2
// instance for the small frames and a default 8x8 instance for the rest.
module tb_maxpool_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int total = 0;
  int bad = 0;

  // small 4x2 instance
  logic       s_start, s_busy, s_done, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0] s_in_pixel, s_mp1, s_mp2, s_mp3, s_mp4, s_mp_max, s_out_pixel;
  logic [0:0] s_out_row;
  logic [1:0] s_out_col;

  // default 8x8 instance
  logic       b_start, b_busy, b_done, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0] b_in_pixel, b_mp1, b_mp2, b_mp3, b_mp4, b_mp_max, b_out_pixel;
  logic [2:0] b_out_row;
  logic [2:0] b_out_col;

  logic [3:0] s_pix [8] = '{4'd1, 4'd9, 4'd3, 4'd2, 4'd4, 4'd5, 4'd15, 4'd0};

  maxpool_sched #(.IMG_W(4), .IMG_H(2), .PIX_W(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .in_pixel(s_in_pixel), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mp_pixel1(s_mp1), .mp_pixel2(s_mp2), .mp_pixel3(s_mp3), .mp_pixel4(s_mp4),
    .mp_maximum(s_mp_max), .out_pixel(s_out_pixel), .out_row(s_out_row),
    .out_col(s_out_col), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  maxpool_sched u_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .in_pixel(b_in_pixel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mp_pixel1(b_mp1), .mp_pixel2(b_mp2), .mp_pixel3(b_mp3), .mp_pixel4(b_mp4),
    .mp_maximum(b_mp_max), .out_pixel(b_out_pixel), .out_row(b_out_row),
    .out_col(b_out_col), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  function automatic logic [3:0] max4(input logic [3:0] a, b, c, d);
    logic [3:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // external maxpool units: registered, one cycle after issue
  always_ff @(posedge clk) begin
    s_mp_max <= max4(s_mp1, s_mp2, s_mp3, s_mp4);
    b_mp_max <= max4(b_mp1, b_mp2, b_mp3, b_mp4);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_small(input bit stall);
    int idx = 0;
    int outn = 0;
    int dn = 0;
    int stall_left = 0;
    int iss = 0;
    bit seen = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy_up", s_busy, 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (s_done) begin
        dn++;
        break;
      end
      if (iss == 6) chk("s_win0", {s_mp1, s_mp2, s_mp3, s_mp4}, 16'h1945);
      if (iss == 8) chk("s_win1", {s_mp1, s_mp2, s_mp3, s_mp4}, 16'h32F0);
      iss = 0;
      if (stall && s_out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 10;
      end
      s_out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        chk("s_hold", s_out_pixel, 9);
        stall_left--;
      end
      s_in_valid = (idx < 8);
      s_in_pixel = s_pix[idx & 7];
      #1;
      if (s_out_valid && !s_out_ready && idx == 7) chk("s_in_ready_low", s_in_ready, 0);
      if (s_out_valid && s_out_ready) begin
        if (outn == 0) chk("s_out0", {s_out_pixel, 3'(s_out_row), s_out_col}, {4'd9, 3'd0, 2'd0});
        if (outn == 1) chk("s_out1", {s_out_pixel, 3'(s_out_row), s_out_col}, {4'd15, 3'd0, 2'd1});
        outn++;
      end
      if (s_in_valid && s_in_ready) begin
        idx++;
        if (idx == 6 || idx == 8) iss = idx;
      end
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (s_done) dn++;
    end
    chk("s_done_cnt", dn, 1);
    chk("s_busy_low", s_busy, 0);
    chk("s_out_cnt", outn, 2);
  endtask

  task automatic run_big(input int pat, input bit gaps, input int abort_at, input bit spam);
    logic [3:0] px [64];
    logic [3:0] ex [16];
    int idx = 0;
    int outn = 0;
    int dn = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        px[r*8+c] = (pat == 0) ? 4'((r*8 + c) % 16) :
                    (pat == 1) ? 4'd15 : 4'((r*5 + c*3 + r*c) % 16);
    for (int pr = 0; pr < 4; pr++)
      for (int pc = 0; pc < 4; pc++)
        ex[pr*4+pc] = max4(px[(2*pr)*8 + 2*pc], px[(2*pr)*8 + 2*pc + 1],
                           px[(2*pr+1)*8 + 2*pc], px[(2*pr+1)*8 + 2*pc + 1]);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (b_done) begin
        dn++;
        break;
      end
      b_out_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_in_valid  = (idx < 64) && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      b_in_pixel  = px[idx & 63];
      b_start     = spam && (cyc == 30 || cyc == 31);
      #1;
      if (spam && cyc == 30) chk("b_busy_mid", b_busy, 1);
      if (b_out_valid && b_out_ready) begin
        if (outn < 16) begin
          chk("b_pix", b_out_pixel, ex[outn]);
          chk("b_row", b_out_row, outn / 4);
          chk("b_col", b_out_col, outn % 4);
        end
        outn++;
      end
      if (b_in_valid && b_in_ready) idx++;
      if (abort_at > 0 && idx == abort_at) break;
      @(negedge clk);
    end
    b_start = 1'b0;
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    if (abort_at > 0) return;
    repeat (6) begin
      @(negedge clk);
      if (b_done) dn++;
    end
    chk("b_done_cnt", dn, 1);
    chk("b_busy_low", b_busy, 0);
    chk("b_out_cnt", outn, 16);
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_pixel = 4'd0; s_out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_pixel = 4'd0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("s_rst", {s_busy, s_done, s_in_ready, s_out_valid, s_out_pixel, s_out_row, s_out_col,
                  s_mp1, s_mp2, s_mp3, s_mp4}, 0);
    chk("b_rst", {b_busy, b_done, b_in_ready, b_out_valid, b_out_pixel, b_out_row, b_out_col,
                  b_mp1, b_mp2, b_mp3, b_mp4}, 0);
    rst = 1'b0;

    run_small(1'b0);
    run_small(1'b1);

    run_big(0, 1'b1, 0, 1'b0);

    run_big(2, 1'b0, 11, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("b_mid_rst", {b_busy, b_done, b_in_ready, b_out_valid, b_out_pixel, b_out_row, b_out_col,
                      b_mp1, b_mp2, b_mp3, b_mp4}, 0);
    rst = 1'b0;
    run_big(2, 1'b1, 0, 1'b0);

    run_big(1, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
